mmio_uart_fifo: RTL and testbench

MMIO_UART_FIFO -- requirements
Module: mmio_uart_fifo

---
 rtl/mmio_pkg.sv | 53 +++++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/mmio_uart_fifo.sv | 151 +++++++++++++++
 tb/tb_mmio_uart_fifo.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg -- shared definitions for the memory-mapped UART FIFO block.
//   Register offsets relative to the block base address, STATUS and CTRL
//   bit positions, the UART byte width, and a small address decoder that
//   turns a bus address into a register selector.
package mmio_pkg;

  localparam int DATA_W = 8;

  localparam logic [31:0] OFF_STATUS  = 32'h00;
  localparam logic [31:0] OFF_TX_DATA = 32'h04;
  localparam logic [31:0] OFF_LED     = 32'h08;
  localparam logic [31:0] OFF_RX_DATA = 32'h0C;
  localparam logic [31:0] OFF_CTRL    = 32'h10;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_TX_DROP    = 4;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 16;

  localparam int CTRL_RX_IE     = 0;
  localparam int CTRL_TX_IE     = 1;
  localparam int CTRL_CLR_DROP  = 8;
  localparam int CTRL_FLUSH_TX  = 9;
  localparam int CTRL_FLUSH_RX  = 10;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATUS,
    REG_TX_DATA,
    REG_LED,
    REG_RX_DATA,
    REG_CTRL
  } reg_sel_e;

  // Exact-match decode: anything outside the five words maps to REG_NONE.
  function automatic reg_sel_e decode_reg(input logic [31:0] addr,
                                          input logic [31:0] base);
    logic [31:0] off;
    off = addr - base;
    case (off)
      OFF_STATUS:  return REG_STATUS;
      OFF_TX_DATA: return REG_TX_DATA;
      OFF_LED:     return REG_LED;
      OFF_RX_DATA: return REG_RX_DATA;
      OFF_CTRL:    return REG_CTRL;
      default:     return REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo -- single-clock circular FIFO.
//   clk, rst   : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write request and data (ignored when full)
//   pop        : read request (ignored when empty)
//   flush      : empties the FIFO this cycle, overriding push and pop
//   full/empty : occupancy flags, count : number of stored entries
//   head       : oldest entry, forced to 0 while empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // Occupancy is judged on the state at the start of the cycle, so a push
  // into a full FIFO is lost even if a pop frees a slot on the same edge.
  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = cnt;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointer and count bookkeeping; pointers wrap naturally because DEPTH is
  // a power of two, and flush has the last word over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array carries no reset; stale contents are never visible
  // because head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_fifo.sv
// mmio_uart_fifo -- CPU register window in front of a TX and an RX byte FIFO.
//   clk, rst              : clock, asynchronous active-low reset
//   cpu_dmem_*            : CPU bus (addr, we, re, wdata in; rdata out, comb)
//   cpu_uart_data_valid/data/ready : TX stream towards the UART sink
//   pdu_uart_data_valid/data/accept: RX stream from the UART source
//   led                   : LED register output
//   irq                   : registered level interrupt
module mmio_uart_fifo
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF0000,
  parameter int          TX_DEPTH  = 8,
  parameter int          RX_DEPTH  = 8,
  parameter int          LED_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_dmem_addr,
  input  logic              cpu_dmem_we,
  input  logic              cpu_dmem_re,
  input  logic [31:0]       cpu_dmem_wdata,
  output logic [31:0]       cpu_dmem_rdata,
  output logic              cpu_uart_data_valid,
  output logic [DATA_W-1:0] cpu_uart_data,
  input  logic              cpu_uart_data_ready,
  input  logic              pdu_uart_data_valid,
  input  logic [DATA_W-1:0] pdu_uart_data,
  output logic              pdu_uart_data_accept,
  output logic [LED_W-1:0]  led,
  output logic              irq
);

  localparam int TXCW = $clog2(TX_DEPTH) + 1;
  localparam int RXCW = $clog2(RX_DEPTH) + 1;

  reg_sel_e          sel;
  logic              tx_push, tx_pop, tx_flush, tx_full, tx_empty;
  logic              rx_push, rx_pop, rx_flush, rx_full, rx_empty;
  logic [TXCW-1:0]   tx_count;
  logic [RXCW-1:0]   rx_count;
  logic [DATA_W-1:0] rx_head;
  logic              ctrl_wr, led_wr;
  logic              tx_drop, rx_ie, tx_ie;
  logic [31:0]       status;
  logic              unused_wdata;

  assign sel     = decode_reg(cpu_dmem_addr, BASE_ADDR);
  assign ctrl_wr = cpu_dmem_we && (sel == REG_CTRL);
  assign led_wr  = cpu_dmem_we && (sel == REG_LED);

  assign tx_push  = cpu_dmem_we && (sel == REG_TX_DATA);
  assign tx_pop   = cpu_uart_data_valid && cpu_uart_data_ready;
  assign tx_flush = ctrl_wr && cpu_dmem_wdata[CTRL_FLUSH_TX];

  // The FIFO ignores an RX pop while empty, so a read of an empty RX_DATA
  // register has no side effect.
  assign rx_push  = pdu_uart_data_valid && pdu_uart_data_accept;
  assign rx_pop   = cpu_dmem_re && (sel == REG_RX_DATA);
  assign rx_flush = ctrl_wr && cpu_dmem_wdata[CTRL_FLUSH_RX];

  assign cpu_uart_data_valid  = !tx_empty;
  assign pdu_uart_data_accept = !rx_full;

  assign unused_wdata = ^cpu_dmem_wdata;

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .din   (cpu_dmem_wdata[DATA_W-1:0]),
    .pop   (tx_pop),
    .flush (tx_flush),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (cpu_uart_data)
  );

  sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .din   (pdu_uart_data),
    .pop   (rx_pop),
    .flush (rx_flush),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count),
    .head  (rx_head)
  );

  // Control state: interrupt enables, the sticky drop flag and the LEDs.
  // A new drop beats a clear landing in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_drop <= 1'b0;
      rx_ie   <= 1'b0;
      tx_ie   <= 1'b0;
      led     <= '0;
    end else begin
      if (ctrl_wr) begin
        rx_ie <= cpu_dmem_wdata[CTRL_RX_IE];
        tx_ie <= cpu_dmem_wdata[CTRL_TX_IE];
      end
      if (tx_push && tx_full) begin
        tx_drop <= 1'b1;
      end else if (ctrl_wr && cpu_dmem_wdata[CTRL_CLR_DROP]) begin
        tx_drop <= 1'b0;
      end
      if (led_wr) led <= cpu_dmem_wdata[LED_W-1:0];
    end
  end

  // Interrupt is sampled from the current FIFO state, so it trails the
  // condition by one clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq <= 1'b0;
    end else begin
      irq <= (rx_ie && !rx_empty) || (tx_ie && tx_empty);
    end
  end

  // STATUS word; counts wider than the 8-bit fields are truncated.
  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_DROP]  = tx_drop;
    status[ST_TX_CNT_LSB +: 8] = 8'(tx_count);
    status[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
  end

  // Zero-latency read mux; write-only and unmapped addresses read 0.
  always_comb begin
    cpu_dmem_rdata = '0;
    case (sel)
      REG_STATUS:  cpu_dmem_rdata = status;
      REG_LED:     cpu_dmem_rdata = 32'(led);
      REG_RX_DATA: cpu_dmem_rdata = 32'(rx_head);
      REG_CTRL: begin
        cpu_dmem_rdata[CTRL_RX_IE] = rx_ie;
        cpu_dmem_rdata[CTRL_TX_IE] = tx_ie;
      end
      default: cpu_dmem_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_mmio_uart_fifo.sv
// tb_mmio_uart_fifo -- directed scenarios followed by random traffic, all
// checked against a queue-based reference model of the register window.
module tb_mmio_uart_fifo;

  localparam int TXD = 8;
  localparam int RXD = 8;
  localparam logic [31:0] BASE     = 32'hFFFF0000;
  localparam logic [31:0] A_STATUS = BASE + 32'h00;
  localparam logic [31:0] A_TX     = BASE + 32'h04;
  localparam logic [31:0] A_LED    = BASE + 32'h08;
  localparam logic [31:0] A_RX     = BASE + 32'h0C;
  localparam logic [31:0] A_CTRL   = BASE + 32'h10;
  localparam logic [31:0] A_BAD    = BASE + 32'h14;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic        we, re;
  logic        tx_valid, ready;
  logic [7:0]  tx_data;
  logic        pvalid, accept;
  logic [7:0]  pdata;
  logic [7:0]  led;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  m_tx[$];
  logic [7:0]  m_rx[$];
  logic        m_drop, m_rx_ie, m_tx_ie, m_irq;
  logic [7:0]  m_led;

  logic        s_valid, s_accept, s_irq;
  logic [7:0]  s_data;
  logic [31:0] rd;

  mmio_uart_fifo #(
    .BASE_ADDR (BASE),
    .TX_DEPTH  (TXD),
    .RX_DEPTH  (RXD),
    .LED_W     (8)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cpu_dmem_addr        (addr),
    .cpu_dmem_we          (we),
    .cpu_dmem_re          (re),
    .cpu_dmem_wdata       (wdata),
    .cpu_dmem_rdata       (rdata),
    .cpu_uart_data_valid  (tx_valid),
    .cpu_uart_data        (tx_data),
    .cpu_uart_data_ready  (ready),
    .pdu_uart_data_valid  (pvalid),
    .pdu_uart_data        (pdata),
    .pdu_uart_data_accept (accept),
    .led                  (led),
    .irq                  (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    if (a == A_STATUS) begin
      v[0]     = (m_tx.size() == TXD);
      v[1]     = (m_tx.size() == 0);
      v[2]     = (m_rx.size() == RXD);
      v[3]     = (m_rx.size() == 0);
      v[4]     = m_drop;
      v[15:8]  = 8'(m_tx.size());
      v[23:16] = 8'(m_rx.size());
    end else if (a == A_LED) begin
      v = {24'b0, m_led};
    end else if (a == A_RX) begin
      v = (m_rx.size() == 0) ? 32'h0 : {24'b0, m_rx[0]};
    end else if (a == A_CTRL) begin
      v = {30'b0, m_tx_ie, m_rx_ie};
    end
    return v;
  endfunction

  task automatic model_reset();
    m_tx.delete();
    m_rx.delete();
    m_drop  = 1'b0;
    m_rx_ie = 1'b0;
    m_tx_ie = 1'b0;
    m_irq   = 1'b0;
    m_led   = 8'h00;
  endtask

  // One bus/stream cycle: drive, compare all outputs with the model, clock,
  // then advance the model from the pre-edge state.
  task automatic applyStimulus(input logic i_we, input logic i_re,
                               input logic [31:0] i_addr,
                               input logic [31:0] i_wdata,
                               input logic i_ready, input logic i_pvalid,
                               input logic [7:0] i_pdata);
    int   txn, rxn;
    logic irq_next, tx_pop, rx_pop, rx_push;
    we = i_we; re = i_re; addr = i_addr; wdata = i_wdata;
    ready = i_ready; pvalid = i_pvalid; pdata = i_pdata;
    #1;
    rd = rdata; s_valid = tx_valid; s_data = tx_data;
    s_accept = accept; s_irq = irq;
    checkOutput("tx_valid", 32'(tx_valid), 32'(m_tx.size() != 0));
    checkOutput("tx_data", 32'(tx_data), (m_tx.size() != 0) ? 32'(m_tx[0]) : 32'h0);
    checkOutput("rx_accept", 32'(accept), 32'(m_rx.size() != RXD));
    checkOutput("rdata", rdata, model_read(i_addr));
    checkOutput("irq", 32'(irq), 32'(m_irq));
    checkOutput("led", 32'(led), 32'(m_led));
    txn      = m_tx.size();
    rxn      = m_rx.size();
    irq_next = (m_rx_ie && rxn != 0) || (m_tx_ie && txn == 0);
    tx_pop   = (txn != 0) && i_ready;
    rx_pop   = i_re && (i_addr == A_RX) && (rxn != 0);
    rx_push  = i_pvalid && (rxn < RXD);
    @(posedge clk);
    #1;
    if (tx_pop) void'(m_tx.pop_front());
    if (i_we && i_addr == A_TX) begin
      if (txn < TXD) m_tx.push_back(i_wdata[7:0]);
      else m_drop = 1'b1;
    end
    if (rx_pop) void'(m_rx.pop_front());
    if (rx_push) m_rx.push_back(i_pdata);
    if (i_we && i_addr == A_CTRL) begin
      m_rx_ie = i_wdata[0];
      m_tx_ie = i_wdata[1];
      if (i_wdata[8])  m_drop = 1'b0;
      if (i_wdata[9])  m_tx.delete();
      if (i_wdata[10]) m_rx.delete();
    end
    if (i_we && i_addr == A_LED) m_led = i_wdata[7:0];
    m_irq = irq_next;
    we = 1'b0; re = 1'b0; ready = 1'b0; pvalid = 1'b0;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b0, a, d, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic bus_rd(input logic [31:0] a);
    applyStimulus(1'b0, 1'b1, a, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic idle(input logic [31:0] a);
    applyStimulus(1'b0, 1'b0, a, 32'h0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog expired before the sequence completed");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          r_sel;
    logic [31:0] r_addr, r_wdata;

    rst = 1'b0; we = 1'b0; re = 1'b0; addr = A_STATUS; wdata = 32'h0;
    ready = 1'b0; pvalid = 1'b0; pdata = 8'h00;
    model_reset();

    // Reset state
    #12;
    checkOutput("rst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("rst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("rst_accept", 32'(accept), 32'h1);
    checkOutput("rst_led", 32'(led), 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    checkOutput("rst_status", rdata, 32'h0000_000A);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // TX bytes held with ready low, then streamed on consecutive cycles
    bus_wr(A_TX, 32'h41);
    bus_wr(A_TX, 32'h42);
    bus_wr(A_TX, 32'h43);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b1, 1'b0, 8'h00);
      checkOutput("tx_stream_valid", 32'(s_valid), 32'h1);
      checkOutput("tx_stream_byte", 32'(s_data), 32'h41 + i);
    end
    idle(A_STATUS);
    checkOutput("tx_stream_done", 32'(s_valid), 32'h0);

    // TX overflow sets the sticky drop flag, CTRL bit 8 clears it
    for (int i = 0; i < 9; i++) bus_wr(A_TX, 32'hA0 + i);
    bus_rd(A_STATUS);
    checkOutput("tx_overflow_status", rd, 32'h0000_0819);
    bus_wr(A_CTRL, 32'h100);
    bus_rd(A_STATUS);
    checkOutput("tx_drop_cleared", rd, 32'h0000_0809);
    bus_wr(A_CTRL, 32'h200);
    bus_rd(A_STATUS);
    checkOutput("tx_flushed", rd, 32'h0000_000A);

    // RX fill to capacity, drain in order, read past empty
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 8'(8'h10 + i));
      checkOutput("rx_fill_accept", 32'(s_accept), 32'h1);
    end
    applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 8'h18);
    checkOutput("rx_full_accept", 32'(s_accept), 32'h0);
    checkOutput("rx_full_status", rd, 32'h0008_0006);
    for (int i = 0; i < 8; i++) begin
      bus_rd(A_RX);
      checkOutput("rx_drain_byte", rd, 32'h10 + i);
    end
    bus_rd(A_RX);
    checkOutput("rx_read_empty", rd, 32'h0);
    bus_rd(A_STATUS);
    checkOutput("rx_no_underflow", rd, 32'h0000_000A);

    // RX read while full with a byte offered: the offered byte waits for
    // accept, then a push+pop pair keeps the count steady
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 8'(8'h20 + i));
    applyStimulus(1'b0, 1'b1, A_RX, 32'h0, 1'b0, 1'b1, 8'h28);
    checkOutput("rx_full_pop_byte", rd, 32'h20);
    checkOutput("rx_full_pop_accept_pre", 32'(s_accept), 32'h0);
    bus_rd(A_STATUS);
    checkOutput("rx_after_full_pop", rd, 32'h0007_0002);
    checkOutput("rx_accept_recovers", 32'(s_accept), 32'h1);
    applyStimulus(1'b0, 1'b1, A_RX, 32'h0, 1'b0, 1'b1, 8'h28);
    checkOutput("rx_pushpop_byte", rd, 32'h21);
    bus_rd(A_STATUS);
    checkOutput("rx_pushpop_count", rd, 32'h0007_0002);
    applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 8'h29);
    bus_rd(A_STATUS);
    checkOutput("rx_refull", rd, 32'h0008_0006);
    for (int i = 0; i < 8; i++) begin
      bus_rd(A_RX);
      checkOutput("rx_order_byte", rd, 32'h22 + i);
    end

    // RX interrupt latency, clear on pop, RX flush
    bus_wr(A_CTRL, 32'h1);
    applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 8'h55);
    idle(A_STATUS);
    checkOutput("irq_pre_latency", 32'(s_irq), 32'h0);
    checkOutput("irq_set", 32'(irq), 32'h1);
    bus_rd(A_RX);
    checkOutput("irq_pop_byte", rd, 32'h55);
    idle(A_STATUS);
    checkOutput("irq_clear", 32'(irq), 32'h0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 8'(8'h60 + i));
    bus_wr(A_CTRL, 32'h400);
    bus_rd(A_STATUS);
    checkOutput("rx_flush_status", rd, 32'h0000_000A);

    // LED write, then reset mid TX stream
    bus_wr(A_LED, 32'hFFFF_FFA5);
    bus_rd(A_LED);
    checkOutput("led_readback", rd, 32'hA5);
    checkOutput("led_pins", 32'(led), 32'hA5);
    bus_wr(A_TX, 32'h71);
    bus_wr(A_TX, 32'h72);
    bus_wr(A_TX, 32'h73);
    applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b0, 1'b1, 8'h81);
    applyStimulus(1'b0, 1'b0, A_STATUS, 32'h0, 1'b1, 1'b1, 8'h82);
    checkOutput("pre_rst_stream", 32'(s_data), 32'h71);
    ready = 1'b1;
    addr  = A_STATUS;
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midrst_led", 32'(led), 32'h0);
    checkOutput("midrst_tx_valid", 32'(tx_valid), 32'h0);
    checkOutput("midrst_tx_data", 32'(tx_data), 32'h0);
    checkOutput("midrst_accept", 32'(accept), 32'h1);
    checkOutput("midrst_irq", 32'(irq), 32'h0);
    checkOutput("midrst_status", rdata, 32'h0000_000A);
    model_reset();
    ready = 1'b0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle(A_STATUS);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      r_sel = int'($urandom_range(0, 7));
      case (r_sel)
        0:       r_addr = A_STATUS;
        1, 5, 6: r_addr = A_TX;
        2:       r_addr = A_LED;
        3:       r_addr = A_RX;
        4:       r_addr = A_CTRL;
        default: r_addr = A_BAD;
      endcase
      r_wdata = $urandom;
      if (r_addr == A_CTRL && $urandom_range(0, 7) != 0) r_wdata[10:9] = 2'b00;
      applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    r_addr, r_wdata, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 1) == 1, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
